// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: matrix geometry, code
// field layout, FSM states and the bounce LFSR polynomial.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 5;

  localparam int COL_LSB = 0;
  localparam int COL_MSB = 1;
  localparam int ROW_LSB = 2;
  localparam int ROW_MSB = 4;

  // Fibonacci taps 16, 14, 13, 11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } state_t;

  function automatic logic [1:0] code_col(input logic [4:0] c);
    return c[COL_MSB:COL_LSB];
  endfunction

  function automatic logic [2:0] code_row(input logic [4:0] c);
    return c[ROW_MSB:ROW_LSB];
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV enabled cycles,
// restarted by clear or whenever disabled.
module keypad_tick_gen #(
  parameter int TICK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en & ~clear & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear | ~en | (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Matrix keypad emulator: presses one key with bounce, hold and gap
// timing by pulling the scanned row/column lines low.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int          TICK_DIV  = 16,
  parameter int          GAP_TICKS = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] x_in,
  input  logic [NUM_ROWS-1:0] y_in,
  output logic [NUM_COLS-1:0] x_pull,
  output logic [NUM_ROWS-1:0] y_pull,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [4:0]          cmd_code,
  input  logic [15:0]         cmd_hold,
  input  logic [3:0]          cmd_bounce,
  output logic                busy,
  output logic                contact,
  output logic                done,
  output logic                err
);

  localparam logic [15:0] GAP_LAST =
    (GAP_TICKS > 0) ? 16'(GAP_TICKS - 1) : 16'd0;

  state_t      state;
  logic [1:0]  col;
  logic [2:0]  row;
  logic [15:0] hold_last;
  logic [3:0]  bounce;
  logic [15:0] cnt;
  logic [15:0] lfsr;
  logic        tick;
  logic        accept;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid & cmd_ready;

  keypad_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      contact   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      col       <= '0;
      row       <= '0;
      hold_last <= '0;
      bounce    <= '0;
      cnt       <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (tick) lfsr <= lfsr_step(lfsr);
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (code_row(cmd_code) < 3'(NUM_ROWS)) begin
              col       <= code_col(cmd_code);
              row       <= code_row(cmd_code);
              hold_last <= (cmd_hold == 16'd0) ? 16'd0
                                               : cmd_hold - 16'd1;
              bounce    <= cmd_bounce;
              cnt       <= '0;
              state     <= BOUNCE_IN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        BOUNCE_IN, BOUNCE_OUT: begin
          if (tick) begin
            if (cnt < {12'd0, bounce}) begin
              contact <= lfsr[0];
              cnt     <= cnt + 16'd1;
            end else begin
              // settle to the steady level of the phase being entered
              contact <= (state == BOUNCE_IN);
              cnt     <= '0;
              state   <= (state == BOUNCE_IN) ? HOLD : GAP;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (cnt == hold_last) begin
              cnt   <= '0;
              state <= BOUNCE_OUT;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (cnt == GAP_LAST) begin
              cnt   <= '0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a line is only pulled while the scanner drives the other group low
  always_comb begin
    x_pull = '0;
    y_pull = '0;
    if (contact && (x_in == '0)) y_pull[row] = 1'b1;
    if (contact && (y_in == '0)) x_pull[col] = 1'b1;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench: cycle model of tick-level contact timeline,
// table vectors, random commands and reset/seed/handshake corners.
module tb_keypad_emulator;

  localparam int          TD   = 2;
  localparam int          GT   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  x_in = '0;
  logic [4:0]  y_in = '0;
  logic [3:0]  x_pull;
  logic [4:0]  y_pull;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_code = '0;
  logic [15:0] cmd_hold = '0;
  logic [3:0]  cmd_bounce = '0;
  logic        busy, contact, done, err;

  keypad_emulator #(
    .TICK_DIV (TD),
    .GAP_TICKS(GT),
    .LFSR_SEED(SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .y_in      (y_in),
    .x_pull    (x_pull),
    .y_pull    (y_pull),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_hold  (cmd_hold),
    .cmd_bounce(cmd_bounce),
    .busy      (busy),
    .contact   (contact),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: queue of per-tick contact codes (0, 1, 2 = LFSR bit)
  bit          m_busy, m_contact, m_done, m_err;
  int          m_c;
  int          q[$];
  logic [15:0] m_lfsr;
  logic [1:0]  m_col;
  logic [2:0]  m_row;

  int   accepts, dones;
  bit   trace_on = 1'b0;
  logic tr[$];
  logic tr1[$];

  typedef struct {
    logic [4:0]  code;
    logic [15:0] hold;
    logic [3:0]  bounce;
    logic        exp_err;
    int          exp_ticks;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic void build_q(input logic [15:0] h,
                                  input logic [3:0] b);
    int hh;
    hh = (h == 0) ? 1 : int'(h);
    q.delete();
    for (int i = 0; i < int'(b); i++) q.push_back(2);
    q.push_back(1);
    for (int i = 0; i < hh; i++) q.push_back(1);
    for (int i = 0; i < int'(b); i++) q.push_back(2);
    q.push_back(0);
    for (int i = 0; i < GT; i++) q.push_back(0);
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_contact = 0; m_done = 0; m_err = 0;
    m_c = 0; m_lfsr = SEED; q.delete();
  endfunction

  task automatic cycle();
    bit          acc;
    logic [4:0]  c;
    logic [15:0] h;
    logic [3:0]  b;
    int          cd;
    logic [3:0]  xe;
    logic [4:0]  ye;
    acc = cmd_valid && !m_busy;
    c = cmd_code; h = cmd_hold; b = cmd_bounce;
    if (cmd_valid && cmd_ready) accepts++;
    @(posedge clk); #1;
    m_done = 0; m_err = 0;
    if (acc) begin
      if (c[4:2] > 3'd4) begin
        m_err = 1;
      end else begin
        build_q(h, b);
        m_busy = 1; m_c = 0;
        m_col = c[1:0]; m_row = c[4:2];
      end
    end else if (m_busy) begin
      m_c++;
      if (m_c == TD) begin
        m_c = 0;
        cd = q.pop_front();
        m_contact = (cd == 2) ? m_lfsr[0] : (cd == 1);
        m_lfsr = lfsr_adv(m_lfsr);
        if (q.size() == 0) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
    if (done) dones++;
    if (trace_on) tr.push_back(contact);
    chk("busy", busy, m_busy);
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("contact", contact, m_contact);
    chk("done", done, m_done);
    chk("err", err, m_err);
    x_in = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
    y_in = ($urandom_range(0, 1) == 1) ? 5'h0 : 5'($urandom);
    #1;
    xe = (m_contact && y_in == 0) ? (4'b1 << m_col) : 4'b0;
    ye = (m_contact && x_in == 0) ? (5'b1 << m_row) : 5'b0;
    chk("x_pull", x_pull, xe);
    chk("y_pull", y_pull, ye);
  endtask

  task automatic do_reset();
    rst = 1; cmd_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_x_pull", x_pull, 0);
    chk("rst_y_pull", y_pull, 0);
    chk("rst_contact", contact, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    chk("rst_ready", cmd_ready, 1);
  endtask

  task automatic send(input logic [4:0] c, input logic [15:0] h,
                      input logic [3:0] b);
    cmd_code = c; cmd_hold = h; cmd_bounce = b; cmd_valid = 1;
    cycle();
    cmd_valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (m_busy && n < budget) begin
      cycle();
      n++;
    end
    chk("idle_timeout", 32'(m_busy), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, diff;
    tbl[0] = '{5'b01010, 16'd4, 4'd0,  1'b0, 10};
    tbl[1] = '{5'b10100, 16'd4, 4'd0,  1'b1, 0};
    tbl[2] = '{5'b00011, 16'd0, 4'd2,  1'b0, 11};
    tbl[3] = '{5'b10011, 16'd1, 4'd15, 1'b0, 37};
    tbl[4] = '{5'b11101, 16'd9, 4'd1,  1'b1, 0};
    tbl[5] = '{5'b00000, 16'd3, 4'd1,  1'b0, 11};

    model_reset();
    do_reset();

    foreach (tbl[i]) begin
      send(tbl[i].code, tbl[i].hold, tbl[i].bounce);
      chk("tbl_err", err, tbl[i].exp_err);
      if (!tbl[i].exp_err) begin
        n = 0;
        do begin
          cycle();
          n++;
        end while (!done && n < 2000);
        chk("tbl_latency", n, tbl[i].exp_ticks * TD);
      end else begin
        repeat (3) cycle();
        chk("tbl_err_busy", busy, 0);
      end
      wait_idle(2000);
    end

    // identical seed gives identical bounce pattern
    do_reset();
    trace_on = 1; tr.delete();
    send(5'b00100, 16'd2, 4'd15);
    wait_idle(500);
    tr1 = tr;
    do_reset();
    tr.delete();
    send(5'b00100, 16'd2, 4'd15);
    wait_idle(500);
    trace_on = 0;
    chk("seed_len", tr.size(), tr1.size());
    diff = 0;
    foreach (tr[i]) if (i < tr1.size() && tr[i] !== tr1[i]) diff++;
    chk("seed_repeat", diff, 0);

    // cmd_valid held: one acceptance per IDLE visit
    do_reset();
    accepts = 0; dones = 0; n = 0;
    cmd_code = 5'b01001; cmd_hold = 16'd1; cmd_bounce = 4'd1;
    cmd_valid = 1;
    while (dones < 3 && n < 500) begin
      cycle();
      n++;
    end
    cmd_valid = 0;
    chk("held_accepts", accepts, 3);
    chk("held_dones", dones, 3);
    wait_idle(100);

    // reset in HOLD drops pulls without a clock edge
    do_reset();
    send(5'b01010, 16'd20, 4'd0);
    repeat (8) cycle();
    x_in = 4'h0; y_in = 5'h1f; #1;
    chk("pre_rst_y_pull", y_pull, 5'b00100);
    rst = 1; #1;
    chk("async_x_pull", x_pull, 0);
    chk("async_y_pull", y_pull, 0);
    chk("async_contact", contact, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    do_reset();
    dones = 0;
    send(5'b01010, 16'd2, 4'd1);
    wait_idle(200);
    chk("post_rst_done", dones, 1);

    // random commands, including invalid rows
    do_reset();
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) cycle();
      send(5'($urandom), 16'($urandom_range(0, 6)),
           4'($urandom_range(0, 4)));
      wait_idle(1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
